dmem_responder: RTL and testbench

Responder end of the `mem_dcache` request interface driven by the execute stage. It accepts one load/store per handshake and performs it as a single-word transaction on the memory-side read/write bus. For loads it returns the 32-bit word; for stores it returns a completion pulse. It sits between execute/mem and the AXI bridge, in place of the data cache, for bring-up and uncached regions.

---
 rtl/dmem_responder_pkg.sv | 32 +++
 rtl/dmem_wbuf.sv | 44 ++++
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the dmem_responder slice: FSM states, op encoding and the latched request record.
// The write buffer is enabled by defining DMEM_WRITE_BUFFER_EN.
package dmem_responder_pkg;

   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_STRB_W = DMEM_DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      RESP    = 3'd4
   } dmem_state_t;

   localparam logic DMEM_OP_LOAD  = 1'b0;
   localparam logic DMEM_OP_STORE = 1'b1;

   typedef struct packed {
      logic [DMEM_ADDR_W-1:0] addr;
      logic                   op;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [DMEM_STRB_W-1:0] wstrb;
   } dmem_req_t;

   // Memory side is word addressed; byte offset bits are cleared.
   function automatic logic [DMEM_ADDR_W-1:0] word_addr(input logic [DMEM_ADDR_W-1:0] a);
      return a & ~DMEM_ADDR_W'(3);
   endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry store buffer: captures a store on push and holds wr_req until memory takes it.
// Instantiated by dmem_responder only when DMEM_WRITE_BUFFER_EN is defined.
module dmem_wbuf
   import dmem_responder_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  dmem_req_t              push_req,
   output logic                   empty,
   output logic                   wr_req,
   output logic [DMEM_ADDR_W-1:0] wr_addr,
   output logic [DMEM_DATA_W-1:0] wr_data,
   output logic [DMEM_STRB_W-1:0] wr_wstrb,
   input  logic                   wr_rdy
);

   logic      full_q;
   dmem_req_t ent_q;
   logic      unused_op;

   // The parent only pushes while empty, so push and drain never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         ent_q  <= '0;
      end else begin
         if (push) begin
            full_q <= 1'b1;
            ent_q  <= push_req;
         end else if (full_q && wr_rdy) begin
            full_q <= 1'b0;
         end
      end
   end

   assign empty     = !full_q;
   assign wr_req    = full_q;
   assign wr_addr   = ent_q.addr;
   assign wr_data   = ent_q.wdata;
   assign wr_wstrb  = ent_q.wstrb;
   assign unused_op = ent_q.op;

endmodule

// File: rtl/dmem_responder.sv
// Uncached data-memory responder: one load/store per handshake, one bus transaction each.
// Define DMEM_WRITE_BUFFER_EN to complete stores early through a one-entry write buffer.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic                op,
   input  logic [ADDR_W-1:0]   virtual_addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic                addr_ok,
   output logic                data_ok,
   output logic [DATA_W-1:0]   rdata,
   output logic                rd_req,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic                rd_rdy,
   input  logic                ret_valid,
   input  logic [DATA_W-1:0]   ret_data,
   output logic                wr_req,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic [DATA_W/8-1:0] wr_wstrb,
   input  logic                wr_rdy,
   output dmem_state_t         dbg_state
);

`ifdef DMEM_WRITE_BUFFER_EN
   localparam bit WBUF_EN = 1'b1;
`else
   localparam bit WBUF_EN = 1'b0;
`endif

   // valid/ready: a request transfers on a cycle where valid && addr_ok; the
   // memory side transfers on rd_req && rd_rdy / wr_req && wr_rdy, and the
   // request outputs hold steady until that transfer.
   dmem_state_t       state;
   dmem_state_t       state_nxt;
   dmem_req_t         req_q;
   dmem_req_t         req_d;
   logic [DATA_W-1:0] rdata_q;
   logic              wbuf_empty;
   logic              accept;
   logic              unused_req;

   always_comb begin
      req_d       = '0;
      req_d.addr  = word_addr(virtual_addr);
      req_d.op    = op;
      req_d.wdata = wdata;
      req_d.wstrb = wstrb;
   end

   assign addr_ok = valid && (state == IDLE) && wbuf_empty;
   assign accept  = addr_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_q <= req_d;
         end
         if ((state == RD_WAIT) && ret_valid) begin
            rdata_q <= ret_data;
         end
      end
   end

   // A buffered store completes straight from IDLE; its bus write drains in dmem_wbuf.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (op == DMEM_OP_LOAD) begin
                  state_nxt = RD_REQ;
               end else begin
                  state_nxt = WBUF_EN ? RESP : WR_REQ;
               end
            end
         end
         RD_REQ: begin
            if (rd_rdy) state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (ret_valid) state_nxt = RESP;
         end
         WR_REQ: begin
            if (wr_rdy) state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign rd_req    = (state == RD_REQ);
   assign rd_addr   = req_q.addr;
   assign data_ok   = (state == RESP);
   assign rdata     = rdata_q;
   assign dbg_state = state;

`ifdef DMEM_WRITE_BUFFER_EN
   assign unused_req = ^{req_q.op, req_q.wdata, req_q.wstrb};

   dmem_wbuf u_wbuf (
      .clk      (clk),
      .rst      (rst),
      .push     (accept && (op == DMEM_OP_STORE)),
      .push_req (req_d),
      .empty    (wbuf_empty),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_wstrb (wr_wstrb),
      .wr_rdy   (wr_rdy)
   );
`else
   assign unused_req = req_q.op;
   assign wbuf_empty = 1'b1;
   assign wr_req     = (state == WR_REQ);
   assign wr_addr    = req_q.addr;
   assign wr_data    = req_q.wdata;
   assign wr_wstrb   = req_q.wstrb;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder; define DMEM_WRITE_BUFFER_EN here too to check the buffered build.
`timescale 1ns/1ps
module tb_dmem_responder;
   import dmem_responder_pkg::*;

`ifdef DMEM_WRITE_BUFFER_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, op = 1'b0;
   logic [31:0] virtual_addr = '0, wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        addr_ok, data_ok, rd_req, wr_req;
   logic [31:0] rdata, rd_addr, wr_addr, wr_data;
   logic [3:0]  wr_wstrb;
   logic        rd_rdy = 1'b0, ret_valid = 1'b0, wr_rdy = 1'b0;
   logic [31:0] ret_data = '0;
   dmem_state_t dbg_state;

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk(clk), .rst(rst), .valid(valid), .op(op), .virtual_addr(virtual_addr),
      .wdata(wdata), .wstrb(wstrb), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
      .ret_data(ret_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_wstrb(wr_wstrb), .wr_rdy(wr_rdy), .dbg_state(dbg_state)
   );

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5A5_5A5A;
   endfunction

   function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      w = mem_rd(a);
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      mem[a] = w;
   endfunction

   // ---------------- transaction-level reference model + compare ----------------
   typedef struct packed {
      logic        op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } txn_t;

   txn_t        cur, wst;
   bit          outstanding, rd_owed, wr_owed, waiting_ret, wbuf_pending, done_due, post_rst;
   logic [31:0] exp_q[$];
   int          cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, wr_hs_cyc = 0, wr_stall_cnt = 0;
   logic [31:0] seen_rd_addr = '0, seen_rdata = '0, seen_wr_addr = '0;
   logic [3:0]  seen_wr_wstrb = '0;
   bit          rd_hs_flag = 1'b0;
   logic [31:0] rd_hs_addr = '0;

   always @(negedge clk) begin
      bit free, nxt_done;
      cyc++;
      if (rst) begin
         outstanding = 0; rd_owed = 0; wr_owed = 0; waiting_ret = 0;
         wbuf_pending = 0; done_due = 0; rd_hs_flag = 0; post_rst = 1;
         exp_q.delete();
      end else begin
         free = !outstanding && !wbuf_pending;
         if (post_rst) begin
            chk("rst_data_ok", data_ok, 0);
            chk("rst_rd_req", rd_req, 0);
            chk("rst_wr_req", wr_req, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_wr_wstrb", wr_wstrb, 0);
            chk("rst_state", dbg_state, IDLE);
            post_rst = 0;
         end
         chk("addr_ok", addr_ok, valid && free);
         chk("data_ok", data_ok, done_due);
         if (data_ok) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (done_due && cur.op == DMEM_OP_LOAD) begin
            if (exp_q.size() == 0) chk("rdata_queue", 32'(exp_q.size()), 1);
            else chk("rdata", rdata, exp_q.pop_front());
            seen_rdata = rdata;
         end
         chk("rd_req", rd_req, rd_owed);
         if (rd_owed) begin
            chk("rd_addr", rd_addr, cur.addr);
            seen_rd_addr = rd_addr;
         end
         chk("wr_req", wr_req, wr_owed);
         if (wr_owed) begin
            chk("wr_addr", wr_addr, wst.addr);
            chk("wr_data", wr_data, wst.wdata);
            chk("wr_wstrb", wr_wstrb, wst.wstrb);
            seen_wr_addr = wr_addr;
            seen_wr_wstrb = wr_wstrb;
            if (!wr_rdy) wr_stall_cnt++;
         end

         // advance the model by what happened this cycle
         nxt_done = 0;
         if (done_due) outstanding = 0;
         if (waiting_ret && ret_valid) begin
            waiting_ret = 0;
            nxt_done = 1;
            exp_q.push_back(mem_rd(cur.addr));
         end
         if (rd_owed && rd_rdy) begin
            rd_owed = 0;
            waiting_ret = 1;
            rd_hs_flag = 1;
            rd_hs_addr = cur.addr;
         end
         if (wr_owed && wr_rdy) begin
            wr_owed = 0;
            mem_wr(wst.addr, wst.wdata, wst.wstrb);
            wr_hs_cyc = cyc;
            if (WBUF) wbuf_pending = 0;
            else nxt_done = 1;
         end
         if (valid && free) begin
            cur.op = op;
            cur.addr = virtual_addr & ~32'h3;
            cur.wdata = wdata;
            cur.wstrb = wstrb;
            outstanding = 1;
            acc_cyc = cyc;
            if (op == DMEM_OP_LOAD) begin
               rd_owed = 1;
            end else begin
               wst = cur;
               wr_owed = 1;
               if (WBUF) begin
                  wbuf_pending = 1;
                  nxt_done = 1;
               end
            end
         end
         done_due = nxt_done;
      end
   end

   // ---------------- memory-side driver ----------------
   int          ret_min = 0, ret_max = 0, wr_hold = 0, ret_cnt = 0;
   bit          rd_rand = 0, wr_rand = 0, stray_en = 0, ret_act = 0;
   logic [31:0] ret_addr = '0;

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rd_hs_flag) begin
            rd_hs_flag = 0;
            ret_act = 1;
            ret_addr = rd_hs_addr;
            ret_cnt = $urandom_range(ret_min, ret_max);
         end
         ret_valid = 1'b0;
         ret_data = $urandom;
         if (ret_act) begin
            if (ret_cnt == 0) begin
               ret_valid = 1'b1;
               ret_data = mem_rd(ret_addr);
               ret_act = 0;
            end else begin
               ret_cnt--;
            end
         end else if (stray_en && $urandom_range(0, 7) == 0) begin
            ret_valid = 1'b1;
         end
         rd_rdy = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (wr_hold > 0 && wr_req) begin
            wr_rdy = 1'b0;
            wr_hold--;
         end else begin
            wr_rdy = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // ---------------- execute-side driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic o, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit hold);
      int n;
      n = 0;
      valid = 1'b1; op = o; virtual_addr = a; wdata = d; wstrb = s;
      @(negedge clk);
      while (!addr_ok && n < 300) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!addr_ok) begin
         bad++;
         $display("FAIL accept_timeout: addr_ok %b after %0d cycles, required 1", addr_ok, n);
      end
      @(posedge clk); #1;
      if (!hold) begin
         valid = 1'b0; op = 1'($urandom); virtual_addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
      end
   endtask

   task automatic wait_done(input int base);
      int n;
      n = 0;
      while (done_cnt <= base && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (done_cnt <= base) begin
         bad++;
         $display("FAIL done_timeout: done count %0d, required more than %0d", done_cnt, base);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int base, a1, a2, load_acc;
      tick(3);
      rst = 1'b0;
      tick(2);

      // load, data returned one cycle after the read handshake
      mem[32'h1C00_0004] = 32'hDEAD_BEEF;
      base = done_cnt;
      do_req(DMEM_OP_LOAD, 32'h1C00_0006, 32'h0, 4'h0, 0);
      wait_done(base);
      chk("t1_latency", 32'(done_cyc - acc_cyc), 3);
      chk("t1_rd_addr", seen_rd_addr, 32'h1C00_0004);
      chk("t1_rdata", seen_rdata, 32'hDEAD_BEEF);
      tick(2);

      // store with memory stalling the write for 4 cycles
      wr_hold = 4;
      wr_stall_cnt = 0;
      tick(1);
      base = done_cnt;
      do_req(DMEM_OP_STORE, 32'h8000_0011, 32'h0000_00AB, 4'b0010, 0);
      wait_done(base);
      chk("t2_latency", 32'(done_cyc - acc_cyc), WBUF ? 32'd1 : 32'd6);
      tick(10);
      chk("t2_wr_addr", seen_wr_addr, 32'h8000_0010);
      chk("t2_wr_wstrb", seen_wr_wstrb, 4'b0010);
      chk("t2_stall_cycles", wr_stall_cnt, 4);

      // store then immediate load of the same word
      wr_hold = 3;
      ret_max = 1;
      tick(1);
      base = done_cnt;
      do_req(DMEM_OP_STORE, 32'h0000_0200, 32'h1234_5678, 4'hF, 0);
      do_req(DMEM_OP_LOAD, 32'h0000_0202, 32'h0, 4'h0, 0);
      load_acc = acc_cyc;
      wait_done(base + 1);
      chk("t3_rdata", seen_rdata, 32'h1234_5678);
      chk("t3_load_after_write", 32'(load_acc > wr_hs_cyc), 1);
      tick(3);

      // back-to-back loads with valid held high
      ret_max = 0;
      tick(1);
      base = done_cnt;
      do_req(DMEM_OP_LOAD, 32'h0000_0040, 32'h0, 4'h0, 1);
      a1 = acc_cyc;
      do_req(DMEM_OP_LOAD, 32'h0000_0044, 32'h0, 4'h0, 0);
      a2 = acc_cyc;
      wait_done(base + 1);
      chk("t4_second_accept_gap", 32'(a2 - a1 >= 4), 1);
      tick(3);

      // reset while waiting for read data; the late return must be ignored
      ret_min = 3;
      ret_max = 3;
      tick(1);
      base = done_cnt;
      do_req(DMEM_OP_LOAD, 32'h0000_0100, 32'h0, 4'h0, 0);
      tick(1);
      chk("t5_in_rd_wait", dbg_state, RD_WAIT);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(8);
      chk("t5_no_data_ok", 32'(done_cnt - base), 0);
      ret_min = 0;
      ret_max = 3;

      // randomized traffic on a small address pool
      rd_rand = 1;
      wr_rand = 1;
      stray_en = 1;
      tick(1);
      for (int i = 0; i < 300; i++) begin
         logic        o;
         logic [31:0] a;
         logic [3:0]  s;
         o = 1'($urandom_range(0, 1));
         a = 32'h0000_3000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         s = 4'($urandom_range(0, 15));
         do_req(o, a, $urandom, s, 0);
         if ($urandom_range(0, 2) == 0) tick($urandom_range(0, 3));
      end
      rd_rand = 0;
      wr_rand = 0;
      stray_en = 0;
      tick(20);
      chk("final_idle", dbg_state, IDLE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t reached, required completion earlier", $time);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
